// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
package key_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    COMMIT = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam int KEY_WIDTH_DEFAULT = 16;

  // XOR of all key bits plus the parity bit must equal this for a good frame.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/key_loader_shift_par.sv
// Shadow shift register, accepted-bit counter and running parity for one key frame.
module key_shift_par #(
  parameter int KEY_WIDTH = 16,
  parameter int CNT_WIDTH = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [KEY_WIDTH-1:0] shadow,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 par
);

  // clr wins over shift_en so a zeroize never lets a bit slip in.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
    end else if (shift_en) begin
      shadow <= {shadow[KEY_WIDTH-2:0], bit_in};
      cnt    <= cnt + CNT_WIDTH'(1);
      par    <= par ^ bit_in;
    end
  end

endmodule

// File: rtl/key_loader.sv
// Serial key loader: assembles a parity-protected frame and commits only verified keys.
module key_loader
  import key_loader_pkg::*;
#(
  parameter  int KEY_WIDTH = KEY_WIDTH_DEFAULT,
  localparam int CNT_WIDTH = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 zeroize,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  output logic                 ser_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(KEY_WIDTH - 1);

  state_t                 state;
  logic [KEY_WIDTH-1:0]   shadow;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   par;
  logic                   hs;
  logic                   clr;
  logic                   shift_en;

  // ser_ready is the only decoded output; zeroize masks it in the same cycle.
  assign ser_ready = ((state == SHIFT) || (state == PARITY)) && !zeroize;
  assign hs        = ser_valid && ser_ready;
  assign clr       = zeroize || ((state == IDLE) && start);
  assign shift_en  = hs && (state == SHIFT);

  key_shift_par #(
    .KEY_WIDTH(KEY_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_shift_par (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (shift_en),
    .bit_in   (ser_data),
    .shadow   (shadow),
    .cnt      (cnt),
    .par      (par)
  );

  // The previous key stays live through a reload until COMMIT or ERROR.
  always_ff @(posedge clk) begin
    if (!rst_n || zeroize) begin
      state     <= IDLE;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        SHIFT: begin
          if (hs && (cnt == LAST_CNT)) state <= PARITY;
        end
        PARITY: begin
          if (hs) begin
            busy  <= 1'b0;
            state <= ((par ^ ser_data) == PARITY_EVEN) ? COMMIT : ERROR;
          end
        end
        COMMIT: begin
          key_out   <= shadow;
          key_valid <= 1'b1;
          state     <= IDLE;
        end
        ERROR: begin
          key_out   <= '0;
          key_valid <= 1'b0;
          err       <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
